// File: rtl/comp_distance_pkg.sv
// Shared types and sizing for the population tour-distance engine.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Holds the population geometry, the derived bus widths, the controller
// state encoding and the gene layout used by comp_distance_pop and
// manhattan_leg.
package comp_distance_pkg;

  // Population geometry
  localparam int POP_SIZE = 50;
  localparam int CITIES   = 15;
  localparam int COORD_W  = 5;
  localparam int DIST_W   = 12;

  // Derived widths
  localparam int GENE_W    = 2 * COORD_W;          // one (x, y) city
  localparam int IND_W     = CITIES * GENE_W;      // one individual
  localparam int POP_W     = POP_SIZE * IND_W;     // whole population bus
  localparam int RES_W     = POP_SIZE * DIST_W;    // packed result bus
  localparam int COST_W    = COORD_W + 2;          // |dx|+|dy| <= 2*(2^COORD_W-1)
  localparam int IND_CNT_W = $clog2(POP_SIZE);
  localparam int LEG_CNT_W = $clog2(CITIES);

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Gene layout: x occupies the upper half, y the lower half.
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } gene_t;

  // Index of the city a leg ends at; the last city wraps back to city 0.
  function automatic logic [LEG_CNT_W-1:0] next_city(input logic [LEG_CNT_W-1:0] k);
    if (k == LEG_CNT_W'(CITIES - 1)) begin
      return '0;
    end
    return k + 1'b1;
  endfunction

endpackage : comp_distance_pkg

// File: rtl/manhattan_leg.sv
// Manhattan distance between two cities of a tour.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows inputs.
//
// Ports:
//   gene_a, gene_b : packed (x, y) cities, x in the upper COORD_W bits
//   cost           : |x_a - x_b| + |y_a - y_b|, unsigned
module manhattan_leg
  import comp_distance_pkg::*;
(
  input  logic [GENE_W-1:0] gene_a,
  input  logic [GENE_W-1:0] gene_b,
  output logic [COST_W-1:0] cost
);

  gene_t              a;
  gene_t              b;
  logic [COORD_W-1:0] dx;
  logic [COORD_W-1:0] dy;

  assign a = gene_t'(gene_a);
  assign b = gene_t'(gene_b);

  // Subtract the smaller from the larger so the difference never wraps.
  always_comb begin
    dx = (a.x >= b.x) ? (a.x - b.x) : (b.x - a.x);
    dy = (a.y >= b.y) ? (a.y - b.y) : (b.y - a.y);
  end

  assign cost = COST_W'(dx) + COST_W'(dy);

endmodule : manhattan_leg

// File: rtl/comp_distance_pop.sv
// Tour length of every individual in a GA population, one leg per clock.
// Latency: done first high after edge POP_SIZE*LEGS+1 counted from the start-sampling edge (751 closed, 701 open).
// Backpressure: none; start is a level request, results hold in DONE until start drops.
//
// Ports:
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset, aborts any computation in flight
//   start     : level request, sampled only in IDLE
//   pop       : POP_SIZE individuals of CITIES genes, captured when start is sampled
//   distances : POP_SIZE packed DIST_W results, individual i at [i*DIST_W +: DIST_W]
//   done      : results valid
//
// Build option: define COMP_DISTANCE_OPEN_TOUR_EN to drop the return leg
// (last city back to city 0), giving CITIES-1 legs per individual.
module comp_distance_pop
  import comp_distance_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [POP_W-1:0] pop,
  output logic [RES_W-1:0] distances,
  output logic             done
);

`ifdef COMP_DISTANCE_OPEN_TOUR_EN
  localparam int LEGS = CITIES - 1;
`else
  localparam int LEGS = CITIES;
`endif

  localparam logic [LEG_CNT_W-1:0] LAST_LEG = LEG_CNT_W'(LEGS - 1);
  localparam logic [IND_CNT_W-1:0] LAST_IND = IND_CNT_W'(POP_SIZE - 1);

  state_t                 state;
  logic [POP_W-1:0]       pop_q;
  logic [RES_W-1:0]       dist_q;
  logic [IND_CNT_W-1:0]   ind_cnt;
  logic [LEG_CNT_W-1:0]   leg_cnt;
  logic [DIST_W-1:0]      acc;

  logic [IND_W-1:0]       cur_ind;
  logic [GENE_W-1:0]      gene_a;
  logic [GENE_W-1:0]      gene_b;
  logic [COST_W-1:0]      leg_cost;
  logic [DIST_W-1:0]      acc_sum;

  // Leg datapath: select the current individual, then the two cities of
  // the current leg. The wrap to city 0 is only ever exercised in the
  // closed-tour build, since the open build stops one leg early.
  always_comb begin
    cur_ind = pop_q[int'(ind_cnt) * IND_W +: IND_W];
    gene_a  = cur_ind[int'(leg_cnt) * GENE_W +: GENE_W];
    gene_b  = cur_ind[int'(next_city(leg_cnt)) * GENE_W +: GENE_W];
  end

  manhattan_leg u_leg (
    .gene_a (gene_a),
    .gene_b (gene_b),
    .cost   (leg_cost)
  );

  assign acc_sum = acc + DIST_W'(leg_cost);

  // Controller. done is registered from the state, so it rises the cycle
  // after DONE is entered and falls the cycle after IDLE is re-entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      pop_q   <= '0;
      dist_q  <= '0;
      ind_cnt <= '0;
      leg_cnt <= '0;
      acc     <= '0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Snapshot the population so upstream may move on immediately.
            pop_q   <= pop;
            ind_cnt <= '0;
            leg_cnt <= '0;
            acc     <= '0;
            state   <= BUSY;
          end
        end

        BUSY: begin
          if (leg_cnt == LAST_LEG) begin
            // Final leg: commit the tour total and start the next individual.
            dist_q[int'(ind_cnt) * DIST_W +: DIST_W] <= acc_sum;
            acc     <= '0;
            leg_cnt <= '0;
            if (ind_cnt == LAST_IND) begin
              state <= DONE;
            end else begin
              ind_cnt <= ind_cnt + 1'b1;
            end
          end else begin
            acc     <= acc_sum;
            leg_cnt <= leg_cnt + 1'b1;
          end
        end

        DONE: begin
          done <= 1'b1;
          // A held start must not retrigger; wait for it to drop first.
          if (!start) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign distances = dist_q;

endmodule : comp_distance_pop

// File: tb/tb_comp_distance_pop.sv
// Directed test for comp_distance_pop with hand-computed tour lengths.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_comp_distance_pop;
  import comp_distance_pkg::*;

`ifdef COMP_DISTANCE_OPEN_TOUR_EN
  localparam int EXP_LAT   = 701;
  localparam int OPEN_TOUR = 1;
`else
  localparam int EXP_LAT   = 751;
  localparam int OPEN_TOUR = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [POP_W-1:0] pop;
  logic [RES_W-1:0] distances;
  logic             done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [POP_W-1:0] stim;
  logic [RES_W-1:0] exp_d;

  always #5 clk = ~clk;

  comp_distance_pop dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .pop       (pop),
    .distances (distances),
    .done      (done)
  );

  task automatic check(input string tag, input logic [RES_W-1:0] got, input logic [RES_W-1:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic put_city(input int i, input int k, input int x, input int y);
    gene_t g;
    g.x = COORD_W'(x);
    g.y = COORD_W'(y);
    stim[i*IND_W + k*GENE_W +: GENE_W] = g;
  endtask

  task automatic put_dist(input int i, input int d);
    exp_d[i*DIST_W +: DIST_W] = DIST_W'(d);
  endtask

  // Present stim and let edge 0 sample start; returns just after that edge.
  task automatic kick(input bit hold);
    @(negedge clk);
    pop   = stim;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Count edges until done is seen high, with a bounded budget.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (done !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: done never rose after %0d cycles", n);
    end
  endtask

  task automatic release_start(input string tag);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check(tag, RES_W'(done), RES_W'(0));
  endtask

  // Pattern: individual 0 city 0 at (31,31), everything else at origin.
  task automatic pattern_corner();
    stim  = '0;
    exp_d = '0;
    put_city(0, 0, 31, 31);
    put_dist(0, OPEN_TOUR ? 62 : 124);
  endtask

  // Pattern: alternating extreme corners in individual 49 plus two
  // small hand-worked individuals.
  task automatic pattern_mixed();
    stim  = '0;
    exp_d = '0;
    for (int k = 0; k < CITIES; k++) begin
      put_city(49, k, (k % 2) ? 31 : 0, (k % 2) ? 31 : 0);
    end
    put_dist(49, 868);                     // 14 legs of 62, return leg 0
    put_city(7, 3, 3, 10);
    put_city(7, 4, 5, 2);
    put_dist(7, 30);                       // 13 + 10 + 7
    put_city(20, 14, 1, 2);
    put_dist(20, OPEN_TOUR ? 3 : 6);       // 3 in, 3 back on the return leg
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    pop   = '0;
    stim  = '0;
    exp_d = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", RES_W'(done), RES_W'(0));
    check("rst_dist", distances, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // All-zero population: exact latency and zero results
    kick(1'b0);
    wait_done(n);
    check("zero_lat", RES_W'(n), RES_W'(EXP_LAT));
    check("zero_dist", distances, '0);
    release_start("zero_drop");

    // Single far city in individual 0
    pattern_corner();
    kick(1'b0);
    wait_done(n);
    check("corner_lat", RES_W'(n), RES_W'(EXP_LAT));
    check("corner_dist", distances, exp_d);
    release_start("corner_drop");

    // Top individual, mid individuals, return leg
    pattern_mixed();
    kick(1'b0);
    wait_done(n);
    check("mixed_lat", RES_W'(n), RES_W'(EXP_LAT));
    check("mixed_dist", distances, exp_d);
    check("mixed_ind49", RES_W'(distances[49*DIST_W +: DIST_W]), RES_W'(868));
    release_start("mixed_drop");

    // Population changes during BUSY must be ignored
    pattern_corner();
    kick(1'b0);
    repeat (100) @(negedge clk);
    pop = '1;
    wait_done(n);
    check("capture_dist", distances, exp_d);
    release_start("capture_drop");

    // Reset in the middle of BUSY, then restart
    pattern_mixed();
    kick(1'b0);
    repeat (299) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_done", RES_W'(done), RES_W'(0));
    check("abort_dist", distances, '0);
    @(negedge clk);
    rst_n = 1'b1;
    kick(1'b0);
    wait_done(n);
    check("restart_lat", RES_W'(n), RES_W'(EXP_LAT));
    check("restart_dist", distances, exp_d);
    release_start("restart_drop");

    // Held start: stays in DONE, no recompute even with a new population
    pattern_mixed();
    kick(1'b1);
    wait_done(n);
    check("hold_lat", RES_W'(n), RES_W'(EXP_LAT));
    @(negedge clk);
    pop = '0;
    repeat (20) @(posedge clk);
    #1;
    check("hold_done", RES_W'(done), RES_W'(1));
    check("hold_dist", distances, exp_d);
    release_start("hold_drop");

    // Fresh request with a new population after the hold
    pattern_corner();
    kick(1'b0);
    #1;
    check("rerun_busy_done", RES_W'(done), RES_W'(0));
    wait_done(n);
    check("rerun_lat", RES_W'(n), RES_W'(EXP_LAT));
    check("rerun_dist", distances, exp_d);
    release_start("rerun_drop");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_comp_distance_pop

// File: doc/comp_distance_pop.md
Name: comp_distance_pop

Overview:
- Computes the closed-tour travel distance of every individual in a genetic-algorithm population.
- Each individual encodes a route through 15 cities. Each city is an (x, y) coordinate pair, and distance is Manhattan.
- Sits between population generation and fitness/selection logic.
- Sequential: one tour leg is evaluated per clock, so one adder/abs-diff datapath serves the whole population.

Parameters:
- POP_SIZE, 50, number of individuals.
- CITIES, 15, cities (genes) per individual.
- COORD_W, 5, bits per coordinate. A gene is 2*COORD_W = 10 bits.
- DIST_W, 12, bits per distance result.
- Derived: IND_W = CITIES*2*COORD_W = 150. Population bus = POP_SIZE*IND_W = 7500.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  level request to compute distances.
- pop  in  7500  population vector.
- distances  out  600  packed results (POP_SIZE*DIST_W).
- done  out  1  results valid.

Behaviour:
- Data layout:
  - Individual i = pop[i*150 +: 150].
  - City k of an individual = bits [k*10 +: 10]; x = [9:5], y = [4:0].
  - distances[i*12 +: 12] = distance of individual i.
- Leg cost = |x_a - x_b| + |y_a - y_b|. Computed unsigned; max 62.
- Tour = sum of legs k -> (k+1) mod CITIES over k = 0..CITIES-1 (closed loop, 15 legs). Max 930, so no overflow in 12 bits.
- Reset (rst_n low at a clock edge):
  - state = IDLE, done = 0, distances = 0, counters = 0, accumulator = 0.
  - Reset mid-computation aborts immediately; no partial results survive.
- States:
  - IDLE: done = 0. When start = 1, copy pop into an internal register (later pop changes are ignored), clear the counters and accumulator, then go to BUSY.
  - BUSY: each cycle adds the leg (ind, leg) to the accumulator. On the last leg, write accumulator + leg into distances[ind] and clear the accumulator. After the last leg of the last individual, go to DONE.
  - DONE: done = 1; distances hold. Stay in DONE while start = 1, so no recomputation. When start = 0, return to IDLE (done drops the next cycle).
- Latency:
  - The IDLE edge that samples start is cycle 0.
  - BUSY lasts POP_SIZE*CITIES = 750 cycles.
  - done is first high after edge 751.
- distances entries update progressively during BUSY.
- Consumers read distances only while done = 1.
- start is ignored in BUSY; a pulse or held level are equivalent.

Optional Feature:
- Macro: COMP_DISTANCE_OPEN_TOUR_EN.
- Defined: the return leg (city CITIES-1 -> city 0) is omitted. Each individual takes CITIES-1 = 14 cycles, BUSY lasts 700 cycles, and done is first high after edge 701.
- Undefined: closed tour as specified above.

Decomposition:
- Package comp_distance_pkg holds:
  - POP_SIZE, CITIES, COORD_W, DIST_W, IND_W.
  - State enum {IDLE, BUSY, DONE}.
- Sub-module manhattan_leg: combinational. Inputs are two 10-bit genes; output is a 7-bit |dx| + |dy|.
- Top level holds the FSM, individual/leg counters, the pop capture register and the result register.

Test Plan:
- Reset, pop = 0, start = 1 -> done rises exactly 751 cycles after start is sampled; all 50 distances = 0.
- Individual 0 city 0 = (31,31), all other cities (0,0) -> distance[0] = 124, others 0. With COMP_DISTANCE_OPEN_TOUR_EN: 62, done after 701 cycles.
- Individual 49 cities alternate (0,0)/(31,31), city 14 = (0,0) -> distance[49] = 14*62 = 868. Confirms top-slice indexing and the 12-bit width.
- Change pop during BUSY -> results still match the pop captured at start.
- Assert rst_n = 0 at cycle 300 of BUSY -> distances = 0, done = 0; restart gives correct results.
- Hold start high through DONE -> done stays 1 with no recompute. Deassert, then reassert with new pop -> done drops, new results after 751 cycles.
